// File: rtl/bht_btb_rd_predictor.sv
// ---------------------------------------------------------------------------
// bht_btb_rd_predictor
//   Lookup side of the combined BHT/BTB RAM. The fetch PC index drives the
//   synchronous RAM read; one cycle later the returned entry is decoded and a
//   registered prediction (hit / taken / counter / target) is presented to
//   the fetch stage. Writes to the RAM are snooped so that a lookup never
//   decodes a stale entry. Two saturating counters give lookup and hit
//   statistics.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   fetch_pc/fetch_valid  lookup request for this cycle
//   stall                 freeze pipeline: no capture, outputs hold
//   rd_address/rd_data    RAM read port (data returned one cycle later)
//   wr_enable/wr_address/wr_data  snooped RAM write port
//   pred_*                registered prediction for the lookup of two cycles ago
//   lookup_count/hit_count saturating performance counters
//
// Valid semantics: there is no back-pressure handshake. A lookup is accepted
// on every rising edge where stall is low; pred_valid qualifies pred_* as the
// result of an accepted lookup with fetch_valid high. The other pred_* fields
// are still updated for bubbles and must be ignored while pred_valid is low.
//
// Entry layout: [31:0] target, [55:32] tag, [56] valid, [58:57] counter,
// [63:59] unused.
// ---------------------------------------------------------------------------
module bht_btb_rd_predictor #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 24,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        fetch_pc,
    input  logic               fetch_valid,
    input  logic               stall,
    output logic [INDEX_W-1:0] rd_address,
    input  logic [63:0]        rd_data,
    input  logic               wr_enable,
    input  logic [INDEX_W-1:0] wr_address,
    input  logic [63:0]        wr_data,
    output logic               pred_valid,
    output logic [31:0]        pred_pc,
    output logic               pred_hit,
    output logic               pred_taken,
    output logic [1:0]         pred_counter,
    output logic [31:0]        pred_target,
    output logic [CNT_W-1:0]   lookup_count,
    output logic [CNT_W-1:0]   hit_count
);

    // Stage A -> B registers
    logic [31:0]        s1_pc;
    logic               s1_valid;

    // One-cycle delayed copy of the snooped write. The RAM returns the old
    // contents when it is read and written in the same cycle, so a write seen
    // in the lookup's address cycle must be replayed here in the decode cycle.
    logic               fwd_valid;
    logic [INDEX_W-1:0] fwd_addr;
    logic [63:0]        fwd_data;

    // Stage B decode
    logic [INDEX_W-1:0] s1_index;
    logic [TAG_W-1:0]   s1_tag;
    logic [63:0]        entry;
    logic               hit;
    logic               taken;
    logic [1:0]         counter;
    logic [31:0]        target;
    logic               unused_entry_bits;

    assign s1_index = s1_pc[INDEX_W+1:2];
    assign s1_tag   = s1_pc[31:INDEX_W+2];

    // While stalled the held lookup is re-read, so the RAM output tracks any
    // write that lands during the stall.
    assign rd_address = stall ? s1_index : fetch_pc[INDEX_W+1:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_pc    <= 32'd0;
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_pc    <= fetch_pc;
            s1_valid <= fetch_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= 64'd0;
        end else begin
            fwd_valid <= wr_enable;
            fwd_addr  <= wr_address;
            fwd_data  <= wr_data;
        end
    end

    // Newest data wins: a write in the decode cycle, then a write from the
    // address cycle, then the RAM output.
    always_comb begin
        entry = rd_data;
        if (wr_enable && (wr_address == s1_index)) begin
            entry = wr_data;
        end else if (fwd_valid && (fwd_addr == s1_index)) begin
            entry = fwd_data;
        end
        hit     = s1_valid & entry[56] & (entry[32 +: TAG_W] == s1_tag);
        taken   = hit & entry[58];
        counter = hit ? entry[58:57] : 2'b00;
        target  = taken ? entry[31:0] : (s1_pc + 32'd4);
    end

    assign unused_entry_bits = ^entry[63:59];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid   <= 1'b0;
            pred_pc      <= 32'd0;
            pred_hit     <= 1'b0;
            pred_taken   <= 1'b0;
            pred_counter <= 2'b00;
            pred_target  <= 32'd0;
            lookup_count <= '0;
            hit_count    <= '0;
        end else if (!stall) begin
            pred_valid   <= s1_valid;
            pred_pc      <= s1_pc;
            pred_hit     <= hit;
            pred_taken   <= taken;
            pred_counter <= counter;
            pred_target  <= target;
            if (s1_valid && (lookup_count != {CNT_W{1'b1}})) begin
                lookup_count <= lookup_count + 1'b1;
            end
            if (hit && (hit_count != {CNT_W{1'b1}})) begin
                hit_count <= hit_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bht_btb_rd_predictor.sv
// ---------------------------------------------------------------------------
// Bench for bht_btb_rd_predictor. A behavioural synchronous RAM (old data on
// same-cycle read/write) sits on the read port and is written through the
// same write port the DUT snoops. The reference holds the ideal table
// contents (every write visible immediately) and derives each prediction
// from it. The counters are built 8 bits wide so saturation is reachable in
// a short run.
// ---------------------------------------------------------------------------
module tb_bht_btb_rd_predictor;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset_n;
    logic [31:0]      fetch_pc;
    logic             fetch_valid;
    logic             stall;
    logic [5:0]       rd_address;
    logic [63:0]      rd_data = 64'd0;
    logic             wr_enable;
    logic [5:0]       wr_address;
    logic [63:0]      wr_data;
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [1:0]       pred_counter;
    logic [31:0]      pred_target;
    logic [CNT_W-1:0] lookup_count;
    logic [CNT_W-1:0] hit_count;

    bht_btb_rd_predictor #(.INDEX_W(6), .TAG_W(24), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .stall(stall),
        .rd_address(rd_address), .rd_data(rd_data),
        .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_hit(pred_hit),
        .pred_taken(pred_taken), .pred_counter(pred_counter),
        .pred_target(pred_target),
        .lookup_count(lookup_count), .hit_count(hit_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM ----------------
    logic [63:0] mem [0:63] = '{default: 64'd0};
    always @(posedge clk) begin
        rd_data <= mem[rd_address];
        if (wr_enable) mem[wr_address] <= wr_data;
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic             hit;
        logic             taken;
        logic [1:0]       cnt;
        logic [31:0]      target;
        logic [CNT_W-1:0] lc;
        logic [CNT_W-1:0] hc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_exp;
    logic [63:0] model_mem [0:63] = '{default: 64'd0};
    logic [31:0] pend_pc;
    logic        pend_v;
    logic [CNT_W-1:0] m_lc;
    logic [CNT_W-1:0] m_hc;
    int checks;
    int failures;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_pc  = 32'd0;
        pend_v   = 1'b0;
        m_lc     = '0;
        m_hc     = '0;
        last_exp = '0;
    endtask

    // Prediction for the pending lookup from the ideal table contents.
    task automatic push_expect();
        exp_t        r;
        logic [63:0] e;
        e        = model_mem[pend_pc[7:2]];
        r.valid  = pend_v;
        r.pc     = pend_pc;
        r.hit    = pend_v && e[56] && (e[55:32] == pend_pc[31:8]);
        r.taken  = r.hit && e[58];
        r.cnt    = r.hit ? e[58:57] : 2'b00;
        r.target = r.taken ? e[31:0] : pend_pc + 32'd4;
        if (pend_v && m_lc != {CNT_W{1'b1}}) m_lc++;
        if (r.hit && m_hc != {CNT_W{1'b1}}) m_hc++;
        r.lc = m_lc;
        r.hc = m_hc;
        exp_q.push_back(r);
    endtask

    task automatic compare_outputs(input string tag, input exp_t r);
        check({tag, ".pred_valid"},   {63'd0, pred_valid},   {63'd0, r.valid});
        check({tag, ".pred_pc"},      {32'd0, pred_pc},      {32'd0, r.pc});
        check({tag, ".pred_hit"},     {63'd0, pred_hit},     {63'd0, r.hit});
        check({tag, ".pred_taken"},   {63'd0, pred_taken},   {63'd0, r.taken});
        check({tag, ".pred_counter"}, {62'd0, pred_counter}, {62'd0, r.cnt});
        check({tag, ".pred_target"},  {32'd0, pred_target},  {32'd0, r.target});
        check({tag, ".lookup_count"}, {{(64-CNT_W){1'b0}}, lookup_count}, {{(64-CNT_W){1'b0}}, r.lc});
        check({tag, ".hit_count"},    {{(64-CNT_W){1'b0}}, hit_count},    {{(64-CNT_W){1'b0}}, r.hc});
    endtask

    // One clock cycle: drive inputs, update reference, sample at the negedge.
    task automatic cyc(input logic [31:0] pc, input logic fv, input logic st,
                       input logic we, input logic [5:0] wa, input logic [63:0] wd);
        exp_t r;
        fetch_pc    = pc;
        fetch_valid = fv;
        stall       = st;
        wr_enable   = we;
        wr_address  = wa;
        wr_data     = wd;
        if (we) model_mem[wa] = wd;
        if (!st) begin
            push_expect();
            pend_pc = pc;
            pend_v  = fv;
        end
        @(posedge clk);
        @(negedge clk);
        if (!st) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=0 expected=1");
            end else begin
                r = exp_q.pop_front();
                compare_outputs("sb", r);
                last_exp = r;
            end
        end else begin
            compare_outputs("stall_hold", last_exp);
        end
    endtask

    task automatic idle();
        cyc(32'd0, 1'b0, 1'b0, 1'b0, 6'd0, 64'd0);
    endtask

    function automatic logic [63:0] ent(input logic [1:0] c, input logic v,
                                        input logic [23:0] tag, input logic [31:0] tgt);
        ent = {5'b00000, c, v, tag, tgt};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        we;
        logic        wr_late;   // write lands in the cycle after the lookup
        logic [5:0]  wa;
        logic [63:0] wd;
        logic        chk;
        logic        e_hit;
        logic        e_taken;
        logic [1:0]  e_cnt;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [31:0] pc, input logic fv, input logic we,
                                input logic late, input logic [5:0] wa, input logic [63:0] wd,
                                input logic chk, input logic h, input logic t,
                                input logic [1:0] c, input logic [31:0] tg);
        mk = '{pc, fv, we, late, wa, wd, chk, h, t, c, tg};
    endfunction

    logic [63:0] upper_junk;

    initial begin
        checks   = 0;
        failures = 0;
        upper_junk = 64'hF800_0000_0000_0000;
        // cold miss
        vecs[0]  = mk(32'h104, 1, 0, 0, 6'd0, 64'd0, 1, 0, 0, 2'd0, 32'h108);
        // preload strong-taken entry at index 1, tag 1
        vecs[1]  = mk(32'h0, 0, 1, 0, 6'd1, ent(2'b11, 1, 24'h1, 32'h400), 0, 0, 0, 0, 0);
        vecs[2]  = mk(32'h104, 1, 0, 0, 6'd0, 64'd0, 1, 1, 1, 2'd3, 32'h400);
        // tag mismatch
        vecs[3]  = mk(32'h204, 1, 0, 0, 6'd0, 64'd0, 1, 0, 0, 2'd0, 32'h208);
        // weakly not-taken
        vecs[4]  = mk(32'h0, 0, 1, 0, 6'd1, ent(2'b01, 1, 24'h1, 32'h400), 0, 0, 0, 0, 0);
        vecs[5]  = mk(32'h104, 1, 0, 0, 6'd0, 64'd0, 1, 1, 0, 2'd1, 32'h108);
        // stale cnt=00, update in the address cycle
        vecs[6]  = mk(32'h0, 0, 1, 0, 6'd1, ent(2'b00, 1, 24'h1, 32'h400), 0, 0, 0, 0, 0);
        vecs[7]  = mk(32'h104, 1, 1, 0, 6'd1, ent(2'b11, 1, 24'h1, 32'h400), 1, 1, 1, 2'd3, 32'h400);
        // stale cnt=00, update in the decode cycle
        vecs[8]  = mk(32'h0, 0, 1, 0, 6'd1, ent(2'b00, 1, 24'h1, 32'h400), 0, 0, 0, 0, 0);
        vecs[9]  = mk(32'h104, 1, 1, 1, 6'd1, ent(2'b11, 1, 24'h1, 32'h400), 1, 1, 1, 2'd3, 32'h400);
        // RAM itself now holds the update
        vecs[10] = mk(32'h104, 1, 0, 0, 6'd0, 64'd0, 1, 1, 1, 2'd3, 32'h400);
        // top of address space: fall-through target wraps to 0
        vecs[11] = mk(32'hFFFF_FFFC, 1, 0, 0, 6'd0, 64'd0, 1, 0, 0, 2'd0, 32'h0);
        // entry with junk in the ignored bits
        vecs[12] = mk(32'h0, 0, 1, 0, 6'd63, ent(2'b10, 1, 24'hFF_FFFF, 32'h1234) | upper_junk, 0, 0, 0, 0, 0);
        vecs[13] = mk(32'hFFFF_FFFC, 1, 0, 0, 6'd0, 64'd0, 1, 1, 1, 2'd2, 32'h1234);
        // matching tag but valid bit clear
        vecs[14] = mk(32'h108, 1, 1, 0, 6'd2, ent(2'b11, 0, 24'h1, 32'h500), 1, 0, 0, 2'd0, 32'h10C);
    end

    // ---------------- test sequence ----------------
    initial begin
        reset_n     = 1'b0;
        fetch_pc    = 32'd0;
        fetch_valid = 1'b0;
        stall       = 1'b0;
        wr_enable   = 1'b0;
        wr_address  = 6'd0;
        wr_data     = 64'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.pred_valid",   {63'd0, pred_valid}, 64'd0);
        check("reset.lookup_count", {56'd0, lookup_count}, 64'd0);
        check("reset.pred_target",  {32'd0, pred_target}, 64'd0);
        check("reset.rd_address",   {58'd0, rd_address}, 64'd0);
        reset_n = 1'b1;

        // directed table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr_late) begin
                cyc(vecs[i].pc, vecs[i].fv, 1'b0, 1'b0, 6'd0, 64'd0);
                cyc(32'd0, 1'b0, 1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd);
            end else begin
                cyc(vecs[i].pc, vecs[i].fv, 1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd);
                idle();
            end
            if (vecs[i].chk) begin
                check($sformatf("vec%0d.valid", i),  {63'd0, pred_valid}, 64'd1);
                check($sformatf("vec%0d.hit", i),    {63'd0, pred_hit},   {63'd0, vecs[i].e_hit});
                check($sformatf("vec%0d.taken", i),  {63'd0, pred_taken}, {63'd0, vecs[i].e_taken});
                check($sformatf("vec%0d.cnt", i),    {62'd0, pred_counter}, {62'd0, vecs[i].e_cnt});
                check($sformatf("vec%0d.target", i), {32'd0, pred_target}, {32'd0, vecs[i].e_tgt});
            end
        end

        // reset in the middle of back-to-back lookups
        cyc(32'h104, 1'b1, 1'b0, 1'b0, 6'd0, 64'd0);
        cyc(32'h204, 1'b1, 1'b0, 1'b0, 6'd0, 64'd0);
        fetch_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_reset.pred_valid",   {63'd0, pred_valid}, 64'd0);
        check("async_reset.lookup_count", {56'd0, lookup_count}, 64'd0);
        check("async_reset.hit_count",    {56'd0, hit_count}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        idle();
        cyc(32'h104, 1'b1, 1'b0, 1'b0, 6'd0, 64'd0);
        check("post_reset.n_plus_1_valid", {63'd0, pred_valid}, 64'd0);
        idle();
        check("post_reset.n_plus_2_valid", {63'd0, pred_valid}, 64'd1);
        check("post_reset.lookup_count",   {56'd0, lookup_count}, 64'd1);

        // three-cycle stall in the middle of a stream, with a write during it
        cyc(32'h104, 1'b1, 1'b0, 1'b0, 6'd0, 64'd0);
        cyc(32'h204, 1'b1, 1'b0, 1'b0, 6'd0, 64'd0);
        cyc(32'h304, 1'b1, 1'b1, 1'b0, 6'd0, 64'd0);
        cyc(32'h404, 1'b1, 1'b1, 1'b1, 6'd1, ent(2'b10, 1, 24'h2, 32'h777));
        cyc(32'h504, 1'b1, 1'b1, 1'b0, 6'd0, 64'd0);
        cyc(32'h108, 1'b1, 1'b0, 1'b0, 6'd0, 64'd0);
        idle();
        idle();

        // randomised stream: small index/tag space so hits and write collisions happen
        for (int n = 0; n < 200; n++) begin
            logic [31:0] pc;
            logic [63:0] wd;
            pc = {8'd0, 14'd0, 2'($urandom_range(1, 2)), 6'($urandom_range(0, 3)), 2'b00};
            wd = ent(2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) != 0),
                     24'($urandom_range(1, 2)), $urandom);
            cyc(pc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 3)), wd);
        end

        // saturation: keep hitting one entry until both counters pin at all-ones
        cyc(32'd0, 1'b0, 1'b0, 1'b1, 6'd1, ent(2'b11, 1, 24'h1, 32'h400));
        idle();
        for (int n = 0; n < 300; n++) begin
            cyc(32'h104, 1'b1, 1'b0, 1'b0, 6'd0, 64'd0);
        end
        idle();
        idle();
        check("sat.lookup_count", {56'd0, lookup_count}, 64'hFF);
        check("sat.hit_count",    {56'd0, hit_count},    64'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
